// File: rtl/hrmf_seq_ctrl.sv
// hrmf_seq_ctrl: radix-4 DIF FFT sequencer issuing butterfly/twiddle addresses and delayed write-backs
module hrmf_seq_ctrl #(
  parameter int LOG4N = 3,
  parameter int PIPE_LAT = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 HOLD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [LOG4N-1:0]     STAGE,
  output logic                 RD_EN,
  output logic [8*LOG4N-1:0]   RD_ADDR,
  output logic [6*LOG4N-1:0]   TF_ADDR,
  output logic                 WR_EN,
  output logic [8*LOG4N-1:0]   WR_ADDR
);
  localparam int AW = 2 * LOG4N;
  localparam logic [AW-1:0] NB = AW'(1 << (AW - 2));
  localparam logic [LOG4N-1:0] S_LAST = LOG4N'(LOG4N - 1);
  localparam logic [3:0] D_LAST = 4'(PIPE_LAT - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [LOG4N-1:0] s_q, s_d, iss_s;
  logic [AW-1:0] b_q, b_d, iss_b;
  logic [3:0] dc_q, dc_d;
  logic rd_en_q, rd_en_d, done_q, done_d;
  logic [4*AW-1:0] rd_addr_q, rd_addr_d, ad_n;
  logic [3*AW-1:0] tf_q, tf_d, tf_n;
  logic [PIPE_LAT-1:0] sv_q, sv_d;
  logic [4*AW-1:0] sa_q [PIPE_LAT];
  logic [4*AW-1:0] sa_d [PIPE_LAT];
  logic adv, upd, start_ok, run_iss, run_end, fin, drn_nxt, iss;
  function automatic logic [7*AW-1:0] gen(input logic [LOG4N-1:0] s, input logic [AW-1:0] b);
    int sh;
    logic [AW-1:0] l, j, base, e1;
    sh = AW - 2 - 2 * int'(s);
    l = AW'(1) << sh;
    j = b & (l - AW'(1));
    base = ((b >> sh) << (sh + 2)) | j;
    e1 = j << (2 * int'(s));
    return {AW'(e1 + (e1 << 1)), AW'(e1 << 1), e1,
            AW'(base + (l << 1) + l), AW'(base + (l << 1)), AW'(base + l), base};
  endfunction
  // next-state: issue selection, stage/drain sequencing and the write-back delay line
  always_comb begin
    adv = !HOLD;
    start_ok = state_q == IDLE && START && !done_q;
    run_iss = state_q == RUN && adv && b_q != NB;
    run_end = state_q == RUN && adv && b_q == NB;
    fin = state_q == DRAIN && adv && dc_q == D_LAST;
    drn_nxt = fin && s_q != S_LAST;
    iss = start_ok || run_iss || drn_nxt;
    iss_s = drn_nxt ? s_q + 1'b1 : start_ok ? '0 : s_q;
    iss_b = run_iss ? b_q : '0;
    {tf_n, ad_n} = gen(iss_s, iss_b);
    state_d = (start_ok || drn_nxt) ? RUN : run_end ? DRAIN : fin ? IDLE : state_q;
    s_d = iss ? iss_s : fin ? '0 : s_q;
    b_d = iss ? iss_b + 1'b1 : b_q;
    dc_d = run_end ? '0 : (state_q == DRAIN && adv) ? dc_q + 1'b1 : dc_q;
    done_d = fin && !drn_nxt;
    upd = adv || start_ok;
    rd_en_d = upd ? iss : rd_en_q;
    rd_addr_d = upd ? (iss ? ad_n : '0) : rd_addr_q;
    tf_d = upd ? (iss ? tf_n : '0) : tf_q;
    sv_d[0] = adv ? rd_en_q : sv_q[0];
    sa_d[0] = adv ? rd_addr_q : sa_q[0];
    for (int i = 1; i < PIPE_LAT; i++) begin
      sv_d[i] = adv ? sv_q[i-1] : sv_q[i];
      sa_d[i] = adv ? sa_q[i-1] : sa_q[i];
    end
  end
  // state registers; reset discards any in-flight write-backs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s_q <= '0;
      b_q <= '0;
      dc_q <= '0;
      done_q <= 1'b0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      tf_q <= '0;
      sv_q <= '0;
      sa_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      b_q <= b_d;
      dc_q <= dc_d;
      done_q <= done_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tf_q <= tf_d;
      sv_q <= sv_d;
      sa_q <= sa_d;
    end
  end
  assign BUSY = state_q != IDLE;
  assign DONE = done_q;
  assign STAGE = s_q;
  assign RD_EN = rd_en_q && !HOLD;
  assign RD_ADDR = rd_addr_q;
  assign TF_ADDR = tf_q;
  assign WR_EN = sv_q[PIPE_LAT-1] && !HOLD;
  assign WR_ADDR = sa_q[PIPE_LAT-1];
endmodule

// File: tb/tb_hrmf_seq_ctrl.sv
// tb_hrmf_seq_ctrl: randomized and directed checks of hrmf_seq_ctrl against a progress-count reference model
module tb_hrmf_seq_ctrl;
  localparam int LG = 3;
  localparam int P = 2;
  localparam int AW = 2 * LG;
  localparam int N = 64;
  localparam int NB = N / 4;
  localparam int T = LG * (NB + P);
  logic clk = 1'b0;
  logic rst, start, hold, s_start;
  logic busy, done, rd_en, wr_en;
  logic [LG-1:0] stage;
  logic [4*AW-1:0] rd_addr, wr_addr;
  logic [3*AW-1:0] tf_addr;
  logic sm_busy, sm_done, sm_rd_en, sm_wr_en;
  logic [0:0] sm_stage;
  logic [7:0] sm_rd_addr, sm_wr_addr;
  logic [5:0] sm_tf_addr;
  int errs = 0, checks = 0;
  int cn = 0, done_cn = 0, n_rd = 0, n_wr = 0;
  int m_mode = 0, m_k = 0;
  always #5 clk = ~clk;
  hrmf_seq_ctrl #(.LOG4N(LG), .PIPE_LAT(P)) dut (
    .CLK(clk), .RST(rst), .START(start), .HOLD(hold), .BUSY(busy), .DONE(done),
    .STAGE(stage), .RD_EN(rd_en), .RD_ADDR(rd_addr), .TF_ADDR(tf_addr),
    .WR_EN(wr_en), .WR_ADDR(wr_addr)
  );
  hrmf_seq_ctrl #(.LOG4N(1), .PIPE_LAT(1)) u_small (
    .CLK(clk), .RST(rst), .START(s_start), .HOLD(1'b0), .BUSY(sm_busy), .DONE(sm_done),
    .STAGE(sm_stage), .RD_EN(sm_rd_en), .RD_ADDR(sm_rd_addr), .TF_ADDR(sm_tf_addr),
    .WR_EN(sm_wr_en), .WR_ADDR(sm_wr_addr)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cn);
    end
  endtask
  function automatic logic [4*AW-1:0] m_rd(input int s, input int b);
    int l, base;
    logic [4*AW-1:0] r;
    l = N >> (2 * (s + 1));
    base = (b / l) * 4 * l + (b % l);
    for (int m = 0; m < 4; m++) r[m*AW +: AW] = AW'((base + m * l) % N);
    return r;
  endfunction
  function automatic logic [3*AW-1:0] m_tf(input int s, input int b);
    int l, e1;
    l = N >> (2 * (s + 1));
    e1 = ((b % l) << (2 * s)) % N;
    return {AW'((3 * e1) % N), AW'((2 * e1) % N), AW'(e1)};
  endfunction
  task automatic cyc(input logic st, input logic hd, input logic rs);
    int stg, pos;
    logic erd, ewr;
    @(posedge clk);
    #1;
    start = st;
    hold = hd;
    rst = rs;
    @(negedge clk);
    cn++;
    stg = m_k / (NB + P);
    pos = m_k % (NB + P);
    erd = m_mode == 1 && !hd && pos < NB;
    ewr = m_mode == 1 && !hd && pos >= P;
    chk("busy", busy, 64'(m_mode == 1));
    chk("done", done, 64'(m_mode == 2));
    chk("rd_en", rd_en, 64'(erd));
    chk("wr_en", wr_en, 64'(ewr));
    if (m_mode == 1) chk("stage", stage, 64'(stg));
    if (erd) begin
      chk("rd_addr", rd_addr, m_rd(stg, pos));
      chk("tf_addr", tf_addr, m_tf(stg, pos));
    end
    if (ewr) chk("wr_addr", wr_addr, m_rd(stg, pos - P));
    if (rd_en) n_rd++;
    if (wr_en) n_wr++;
    if (done) done_cn = cn;
    if (rs) m_mode = 0;
    else if (m_mode == 0 && st) begin
      m_mode = 1;
      m_k = 0;
      cn = 0;
    end else if (m_mode == 1) begin
      if (!hd) m_k++;
      if (m_k == T) m_mode = 2;
    end else if (m_mode == 2) m_mode = 0;
  endtask
  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    s_start = 1'b0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0);
    chk("rst_addr", {rd_addr, wr_addr, tf_addr}, 64'd0);
    chk("rst_stage", stage, 64'd0);
    cyc(1, 0, 0);
    n_rd = 0;
    n_wr = 0;
    for (int c = 1; c <= 56; c++) begin
      cyc(c == 10 || c == 55 || c == 56, 0, 0);
      if (c == 6) begin
        chk("s0b5_rd", rd_addr, {6'd53, 6'd37, 6'd21, 6'd5});
        chk("s0b5_tf", tf_addr, {6'd15, 6'd10, 6'd5});
      end
      if (c == 24) begin
        chk("s1b5_rd", rd_addr, {6'd29, 6'd25, 6'd21, 6'd17});
        chk("s1b5_tf", tf_addr, {6'd12, 6'd8, 6'd4});
      end
      if (c == 42) begin
        chk("s2b5_rd", rd_addr, {6'd23, 6'd22, 6'd21, 6'd20});
        chk("s2b5_tf", tf_addr, 64'd0);
      end
      if (c == 16) chk("s0b15_tf", tf_addr, {6'd45, 6'd30, 6'd15});
      if (c == 34) chk("s1b15_tf", tf_addr, {6'd36, 6'd24, 6'd12});
      if (c == 55) begin
        chk("n_reads", n_rd, 64'd48);
        chk("n_writes", n_wr, 64'd48);
        chk("done_cycle", done_cn, 64'd55);
      end
    end
    done_cn = 0;
    for (int c = 1; c <= 62; c++) cyc(0, c inside {8, 9, 10, 20, 21}, 0);
    chk("hold_done_cycle", done_cn, 64'd60);
    cyc(1, 0, 0);
    for (int c = 1; c <= 21; c++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("abort_addr", {rd_addr, wr_addr, tf_addr}, 64'd0);
    chk("abort_stage", stage, 64'd0);
    for (int t = 0; t < 6; t++) begin
      cyc(1, $urandom_range(0, 3) == 0, 0);
      guard = 0;
      while (m_mode != 0 && guard < 3000) begin
        cyc($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, 0);
        guard++;
      end
      chk("rand_timeout", 64'(guard < 3000), 64'd1);
      start = 1'b0;
      hold = 1'b0;
      repeat ($urandom_range(0, 3)) cyc(0, 0, 0);
    end
    start = 1'b0;
    hold = 1'b0;
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    @(negedge clk);
    chk("sm_rd_en", sm_rd_en, 64'd1);
    chk("sm_rd_addr", sm_rd_addr, 64'he4);
    chk("sm_tf", sm_tf_addr, 64'd0);
    chk("sm_busy1", sm_busy, 64'd1);
    @(negedge clk);
    chk("sm_wr_en", sm_wr_en, 64'd1);
    chk("sm_wr_addr", sm_wr_addr, 64'he4);
    chk("sm_rd_off", sm_rd_en, 64'd0);
    @(negedge clk);
    chk("sm_done", sm_done, 64'd1);
    chk("sm_busy3", sm_busy, 64'd0);
    chk("sm_wr_off", sm_wr_en, 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
